mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction fetch
// path (read-only) and the load/store path (read/write). One transaction is
// outstanding at a time.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   if_req_*/if_addr      fetch request handshake (valid/ready) and address
//   if_resp_valid/rdata   fetch completion pulse and data
//   ls_req_*/ls_*         load/store request handshake and payload
//   ls_resp_valid/rdata   load/store completion pulse and load data
//   mem_req_*/mem_*       request handshake and payload to memory
//   mem_resp_valid/rdata  memory response strobe and read data
//   busy                  transaction in flight (state != IDLE)
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined: fixed priority, LSU wins a simultaneous request
//   defined:   simultaneous requests alternate using a last_grant register
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [AW-1:0]     if_addr,
  output logic              if_resp_valid,
  output logic [DW-1:0]     if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [AW-1:0]     ls_addr,
  input  logic              ls_wen,
  input  logic [DW-1:0]     ls_wdata,
  input  logic [DW/8-1:0]   ls_wstrb,
  output logic              ls_resp_valid,
  output logic [DW-1:0]     ls_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_wen,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);

  localparam int unsigned SW = DW / 8;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic            wen_q,   wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic            last_grant_q, last_grant_d;
`endif

  logic grant_ls_c;
  logic accept_c;
  logic resp_fire_c;

  // Winner selection; only meaningful while accept_c is high.
  always_comb begin
    grant_ls_c = ls_req_valid;
    if (if_req_valid && ls_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_ls_c = (last_grant_q == OWN_IF);
`else
      grant_ls_c = 1'b1;
`endif
    end
  end

  // rst gating keeps the Mealy readies at 0 while reset is asserted.
  assign accept_c    = rst && (state_q == IDLE) && (if_req_valid || ls_req_valid);
  assign resp_fire_c = (state_q == WAIT) && mem_resp_valid;

  // Next-state and payload latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = ISSUE;
          owner_d = grant_ls_c ? OWN_LS : OWN_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = grant_ls_c ? OWN_LS : OWN_IF;
`endif
          if (grant_ls_c) begin
            addr_d  = ls_addr;
            wen_d   = ls_wen;
            wdata_d = ls_wdata;
            wstrb_d = ls_wstrb;
          end else begin
            // Fetches are reads: write side of the payload is forced to zero.
            addr_d  = if_addr;
            wen_d   = 1'b0;
            wdata_d = DW'(0);
            wstrb_d = SW'(0);
          end
        end
      end
      ISSUE:   if (mem_req_ready)  state_d = WAIT;
      WAIT:    if (mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched payload registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= AW'(0);
      wen_q   <= 1'b0;
      wdata_q <= DW'(0);
      wstrb_q <= SW'(0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= OWN_LS;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Request-side handshakes: ready only in IDLE, in the accept cycle.
  assign if_req_ready = accept_c && !grant_ls_c;
  assign ls_req_ready = accept_c &&  grant_ls_c;

  // Memory request side driven from the latched payload.
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

  // Response routed to the owner; rdata is zero outside its pulse.
  assign if_resp_valid = resp_fire_c && (owner_q == OWN_IF);
  assign ls_resp_valid = resp_fire_c && (owner_q == OWN_LS);
  assign if_rdata      = if_resp_valid ? mem_rdata : DW'(0);
  assign ls_rdata      = ls_resp_valid ? mem_rdata : DW'(0);

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A transaction-level
// reference model predicts the winner of each arbitration and the expected
// memory payload / response routing for a bench-chosen timeline.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic rr_last;  // model: last granted requester, 1 = LSU

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Reference arbitration rule: returns 1 when the LSU should win.
  function automatic logic model_pick_ls(input logic iv, input logic lv);
    if (iv && lv) return RR_MODE ? !rr_last : 1'b1;
    return lv;
  endfunction

  task automatic drive_idle();
    if_req_valid = 0; if_addr = 0;
    ls_req_valid = 0; ls_addr = 0; ls_wen = 0; ls_wdata = 0; ls_wstrb = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
  endtask

  // One complete transaction: accept cycle, d_ready+1 ISSUE cycles,
  // d_resp+1 WAIT cycles. late_ls raises ls_req_valid only after acceptance.
  task automatic run_txn(input logic iv, input logic lv,
                         input logic [31:0] ia, input logic [31:0] la,
                         input logic lw, input logic [31:0] wd, input logic [3:0] ws,
                         input int d_ready, input int d_resp,
                         input logic spur, input logic late_ls,
                         output logic obs_ls);
    logic        exp_ls, lv0, fire, e_ifr, e_lsr;
    logic [31:0] ea, ed, rd;
    logic        ew;
    logic [3:0]  es;
    lv0    = lv && !late_ls;
    exp_ls = model_pick_ls(iv, lv0);
    @(negedge clk);
    if_req_valid = iv; if_addr = ia;
    ls_req_valid = lv0; ls_addr = la; ls_wen = lw; ls_wdata = wd; ls_wstrb = ws;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = $urandom;
    #1;
    checks++;
    if (if_req_ready !== !exp_ls || ls_req_ready !== exp_ls || busy !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL accept: if_rdy=%b ls_rdy=%b busy=%b mreq=%b, required if_rdy=%b ls_rdy=%b busy=0 mreq=0",
               if_req_ready, ls_req_ready, busy, mem_req_valid, !exp_ls, exp_ls);
    end
    obs_ls  = ls_req_ready;
    rr_last = exp_ls;
    if (exp_ls) begin ea = la; ew = lw;   ed = wd; es = ws;   end
    else        begin ea = ia; ew = 1'b0; ed = 0;  es = 4'h0; end

    for (int k = 0; k <= d_ready; k++) begin
      @(negedge clk);
      // Winner drops its request and scribbles its payload to prove latching.
      if (exp_ls) begin ls_req_valid = 0; ls_addr = $urandom; ls_wdata = $urandom; ls_wstrb = 4'($urandom); end
      else        begin if_req_valid = 0; if_addr = $urandom; end
      if (late_ls) ls_req_valid = 1;
      mem_req_ready  = (k == d_ready);
      mem_resp_valid = spur ? 1'($urandom) : 1'b0;
      mem_rdata      = $urandom;
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== ea || mem_wen !== ew || mem_wdata !== ed || mem_wstrb !== es) begin
        failures++;
        $display("FAIL issue_payload: v=%b a=%h w=%b d=%h s=%h, required v=1 a=%h w=%b d=%h s=%h",
                 mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, ea, ew, ed, es);
      end
      checks++;
      if (busy !== 1'b1 || if_req_ready !== 1'b0 || ls_req_ready !== 1'b0 ||
          if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0 || if_rdata !== 0 || ls_rdata !== 0) begin
        failures++;
        $display("FAIL issue_quiet: busy=%b rdy=%b%b resp=%b%b rdata=%h/%h, required busy=1 rdy=00 resp=00 rdata=0/0",
                 busy, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, if_rdata, ls_rdata);
      end
    end

    for (int k = 0; k <= d_resp; k++) begin
      @(negedge clk);
      mem_req_ready  = 1'($urandom);
      fire           = (k == d_resp);
      mem_resp_valid = fire;
      rd             = $urandom;
      mem_rdata      = rd;
      #1;
      e_ifr = fire && !exp_ls;
      e_lsr = fire &&  exp_ls;
      checks++;
      if (mem_req_valid !== 1'b0 || busy !== 1'b1 || if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL wait_state: mreq=%b busy=%b rdy=%b%b, required mreq=0 busy=1 rdy=00",
                 mem_req_valid, busy, if_req_ready, ls_req_ready);
      end
      checks++;
      if (if_resp_valid !== e_ifr || ls_resp_valid !== e_lsr ||
          if_rdata !== (e_ifr ? rd : 32'h0) || ls_rdata !== (e_lsr ? rd : 32'h0)) begin
        failures++;
        $display("FAIL response: resp=%b%b rdata=%h/%h, required resp=%b%b rdata=%h/%h",
                 if_resp_valid, ls_resp_valid, if_rdata, ls_rdata, e_ifr, e_lsr,
                 e_ifr ? rd : 32'h0, e_lsr ? rd : 32'h0);
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 0;
    if_req_valid = 1; ls_req_valid = 1; mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    #7;
    checks++;
    if (if_req_ready !== 0 || ls_req_ready !== 0 || if_resp_valid !== 0 || ls_resp_valid !== 0 ||
        if_rdata !== 0 || ls_rdata !== 0 || mem_req_valid !== 0 || mem_addr !== 0 ||
        mem_wen !== 0 || mem_wdata !== 0 || mem_wstrb !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b%b resp=%b%b mreq=%b addr=%h wen=%b wd=%h ws=%h busy=%b, required all 0",
               if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid,
               mem_addr, mem_wen, mem_wdata, mem_wstrb, busy);
    end
    @(negedge clk); @(negedge clk);
    drive_idle();
    rst = 1;
    rr_last = 1'b1;
  endtask

  task automatic test_single_fetch();
    logic o;
    run_txn(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, o);
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (busy !== 1'b0 || mem_req_valid !== 1'b0 || if_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done: busy=%b mreq=%b if_resp=%b, required 0 0 0", busy, mem_req_valid, if_resp_valid);
    end
  endtask

  task automatic test_store();
    logic o;
    run_txn(0, 1, 0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 1, 2, 0, 0, o);
    checks++;
    if (o !== 1'b1) begin
      failures++;
      $display("FAIL store_grant: ls_rdy=%b, required 1", o);
    end
  endtask

  task automatic test_simultaneous();
    logic o, prev;
    run_txn(1, 1, 32'h0000_1000, 32'h0000_2000, 0, 0, 0, 0, 0, 0, 0, o);
    checks++;
    if (o !== !RR_MODE) begin
      failures++;
      $display("FAIL first_winner: ls_won=%b, required %b", o, !RR_MODE);
    end
    if (o) run_txn(1, 0, 32'h0000_1000, 0, 0, 0, 0, 0, 0, 0, 0, o);
    else   run_txn(0, 1, 0, 32'h0000_2000, 0, 0, 0, 0, 0, 0, 0, o);
    prev = o;
    for (int r = 0; r < 4; r++) begin
      run_txn(1, 1, 32'h100 + 32'(r), 32'h200 + 32'(r), 1, 32'(r), 4'hF, r % 2, 1, 0, 0, o);
      checks++;
      if (o !== (RR_MODE ? !prev : 1'b1)) begin
        failures++;
        $display("FAIL round_%0d: ls_won=%b, required %b", r, o, RR_MODE ? !prev : 1'b1);
      end
      prev = o;
    end
    // Serve the requester left pending by the final round.
    if (prev) run_txn(1, 0, 32'h103, 0, 0, 0, 0, 0, 0, 0, 0, o);
    else      run_txn(0, 1, 0, 32'h203, 1, 32'h3, 4'hF, 0, 0, 0, 0, o);
  endtask

  task automatic test_backpressure();
    logic o;
    run_txn(0, 1, 0, 32'h0000_4440, 1, 32'h1234_5678, 4'b0000, 5, 1, 1, 0, o);
    run_txn(1, 0, 32'h0000_8880, 0, 0, 0, 0, 5, 0, 1, 0, o);
  endtask

  task automatic test_reset_in_wait();
    logic o;
    @(negedge clk);
    drive_idle(); if_req_valid = 1; if_addr = 32'h8000_0040;
    @(negedge clk);
    if_req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #1;
    checks++;
    if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_wait: busy=%b mreq=%b, required 1 0", busy, mem_req_valid);
    end
    #1;
    rst = 0; mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D; if_req_valid = 1;
    #1;
    checks++;
    if (busy !== 0 || mem_req_valid !== 0 || if_resp_valid !== 0 || ls_resp_valid !== 0 ||
        if_req_ready !== 0 || if_rdata !== 0) begin
      failures++;
      $display("FAIL async_reset: busy=%b mreq=%b resp=%b%b if_rdy=%b if_rdata=%h, required all 0",
               busy, mem_req_valid, if_resp_valid, ls_resp_valid, if_req_ready, if_rdata);
    end
    @(negedge clk);
    rst = 1; rr_last = 1'b1;
    if_req_valid = 0; mem_resp_valid = 1;
    #1;
    checks++;
    if (if_resp_valid !== 0 || ls_resp_valid !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL post_reset_resp: resp=%b%b busy=%b, required 00 0", if_resp_valid, ls_resp_valid, busy);
    end
    run_txn(1, 0, 32'h8000_0044, 0, 0, 0, 0, 0, 0, 0, 0, o);
  endtask

  task automatic test_hold();
    logic o;
    run_txn(1, 1, 32'h8000_0100, 32'h8000_2000, 1, 32'h5555_AAAA, 4'b1100, 1, 0, 0, 1, o);
    run_txn(0, 1, 0, 32'h8000_2000, 1, 32'h5555_AAAA, 4'b1100, 0, 0, 0, 0, o);
    checks++;
    if (o !== 1'b1) begin
      failures++;
      $display("FAIL hold_accept: ls_rdy=%b, required 1", o);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (ls_req_ready !== 0 || ls_resp_valid !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL hold_once: ls_rdy=%b ls_resp=%b busy=%b, required 0 0 0", ls_req_ready, ls_resp_valid, busy);
    end
  endtask

  task automatic test_random();
    logic        p_if, p_ls, pw, o;
    logic [31:0] pia, pla, pwd;
    logic [3:0]  pws;
    p_if = 0; p_ls = 0;
    pia = 0; pla = 0; pw = 0; pwd = 0; pws = 0;
    for (int i = 0; i < 60; i++) begin
      if (!p_if) begin p_if = 1'($urandom); pia = $urandom; end
      if (!p_ls) begin
        p_ls = 1'($urandom); pla = $urandom; pw = 1'($urandom); pwd = $urandom; pws = 4'($urandom);
      end
      if (!p_if && !p_ls) p_if = 1;
      run_txn(p_if, p_ls, pia, pla, pw, pwd, pws, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'($urandom), 0, o);
      if (o) p_ls = 0; else p_if = 0;
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    rr_last = 1'b1;
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_backpressure();
    test_reset_in_wait();
    test_hold();
    test_random();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
